// File: rtl/pipeline_stall_ctrl_if.sv
// Pipeline hazard/stall control bus: DX/FD instruction fields and multdiv status
// in, latch hold/bubble/flush controls and multdiv handshake out.
interface pipeline_stall_ctrl_if;
  logic [4:0] dx_opcode;
  logic [4:0] dx_aluop;
  logic [4:0] dx_rd;
  logic [4:0] fd_rs;
  logic [4:0] fd_rt;
  logic       fd_uses_rt;
  logic       md_ready;
  logic       md_exception;
  logic       branch_taken_x;

  logic       md_ctrl_mult;
  logic       md_ctrl_div;
  logic       stall_pc;
  logic       stall_fd;
  logic       stall_dx;
  logic       bubble_dx;
  logic       bubble_xm;
  logic       flush_fd;
  logic       md_done;
  logic       md_err;
  logic       md_timeout;
  logic [7:0] md_cycles;

  modport master (
    output dx_opcode, dx_aluop, dx_rd, fd_rs, fd_rt, fd_uses_rt,
    output md_ready, md_exception, branch_taken_x,
    input  md_ctrl_mult, md_ctrl_div, stall_pc, stall_fd, stall_dx,
    input  bubble_dx, bubble_xm, flush_fd, md_done, md_err, md_timeout, md_cycles
  );

  modport slave (
    input  dx_opcode, dx_aluop, dx_rd, fd_rs, fd_rt, fd_uses_rt,
    input  md_ready, md_exception, branch_taken_x,
    output md_ctrl_mult, md_ctrl_div, stall_pc, stall_fd, stall_dx,
    output bubble_dx, bubble_xm, flush_fd, md_done, md_err, md_timeout, md_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/bubble/flush control for a 5-stage pipeline with a multi-cycle multdiv unit.
// Optional WAIT abort after TIMEOUT_CYCLES is enabled by defining MD_TIMEOUT_EN.
module pipeline_stall_ctrl #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd64
) (
  input  logic                 clock,
  input  logic                 reset,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b01000;
  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] md_cycles_q, md_cycles_d;
  logic       md_err_q, md_err_d;
  logic       md_done_q, md_done_d;
  logic       md_timeout_q, md_timeout_d;

  logic md_op_s;
  logic is_mult_s;
  logic load_use_raw_s;
  logic timeout_hit_s;
  logic md_start_s;
  logic md_hold_s;
  logic branch_s;
  logic load_use_s;

  // Instruction decode and hazard detection on the latched fields
  always_comb begin
    is_mult_s      = (bus.dx_aluop == ALU_MULT);
    md_op_s        = (bus.dx_opcode == OP_RTYPE) &&
                     ((bus.dx_aluop == ALU_MULT) || (bus.dx_aluop == ALU_DIV));
    load_use_raw_s = (bus.dx_opcode == OP_LOAD) && (bus.dx_rd != 5'd0) &&
                     ((bus.fd_rs == bus.dx_rd) ||
                      (bus.fd_uses_rt && (bus.fd_rt == bus.dx_rd)));
  end

`ifdef MD_TIMEOUT_EN
  assign timeout_hit_s = (md_cycles_q == (TIMEOUT_CYCLES - 8'd1)) && !bus.md_ready;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign timeout_hit_s    = 1'b0;
`endif

  // Multdiv sequencing: next state and registered status
  always_comb begin
    state_d      = state_q;
    md_cycles_d  = md_cycles_q;
    md_err_d     = md_err_q;
    md_done_d    = 1'b0;
    md_timeout_d = md_timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (md_op_s) begin
          state_d     = ST_WAIT;
          md_cycles_d = 8'd0;
          md_err_d    = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        md_cycles_d = (md_cycles_q == 8'hFF) ? md_cycles_q : (md_cycles_q + 8'd1);
        if (bus.md_ready) begin
          state_d   = ST_DONE;
          md_err_d  = bus.md_exception;
          md_done_d = 1'b1;
        end else if (timeout_hit_s) begin
          state_d      = ST_DONE;
          md_err_d     = 1'b1;
          md_done_d    = 1'b1;
          md_timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        md_err_d = 1'b0;
      end
      default: begin
        state_d  = ST_IDLE;
        md_err_d = 1'b0;
      end
    endcase
  end

  // State and status registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      md_cycles_q  <= 8'd0;
      md_err_q     <= 1'b0;
      md_done_q    <= 1'b0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      md_cycles_q  <= md_cycles_d;
      md_err_q     <= md_err_d;
      md_done_q    <= md_done_d;
      md_timeout_q <= md_timeout_d;
    end
  end

  // Priority resolution: multdiv hold beats branch flush beats load-use
  always_comb begin
    md_start_s = (state_q == ST_IDLE) && md_op_s;
    md_hold_s  = md_start_s || (state_q == ST_WAIT);
    branch_s   = bus.branch_taken_x && !md_hold_s;
    load_use_s = load_use_raw_s && !md_hold_s && !bus.branch_taken_x;
  end

  // Output drive; everything forced low while reset is held
  always_comb begin
    bus.md_ctrl_mult = 1'b0;
    bus.md_ctrl_div  = 1'b0;
    bus.stall_pc     = 1'b0;
    bus.stall_fd     = 1'b0;
    bus.stall_dx     = 1'b0;
    bus.bubble_dx    = 1'b0;
    bus.bubble_xm    = 1'b0;
    bus.flush_fd     = 1'b0;
    bus.md_done      = 1'b0;
    bus.md_err       = 1'b0;
    bus.md_timeout   = 1'b0;
    bus.md_cycles    = 8'd0;
    if (reset) begin
      bus.md_ctrl_mult = md_start_s && is_mult_s;
      bus.md_ctrl_div  = md_start_s && !is_mult_s;
      bus.stall_pc     = md_hold_s || load_use_s;
      bus.stall_fd     = md_hold_s || load_use_s;
      bus.stall_dx     = md_hold_s;
      bus.bubble_dx    = branch_s || load_use_s;
      bus.bubble_xm    = md_hold_s;
      bus.flush_fd     = branch_s;
      bus.md_done      = md_done_q;
      bus.md_err       = md_err_q;
      bus.md_timeout   = md_timeout_q;
      bus.md_cycles    = md_cycles_q;
    end else begin
      bus.md_cycles = 8'd0;
    end
  end

endmodule
